bin2csd_seq: RTL and testbench

BIN2CSD_SEQ -- requirements
Module: bin2csd_seq

---
 rtl/bin2csd_pkg.sv | 21 ++
 rtl/bin2csd_digit.sv | 41 ++++
 rtl/bin2csd_seq.sv | 151 +++++++++++++++
 tb/tb_bin2csd_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/bin2csd_pkg.sv
// Shared definitions for the bin2csd converter family.
// Holds the two-bit CSD digit codes and the sequential FSM state encoding so
// that the serial recoder and any future parallel variants agree on both.
package bin2csd_pkg;

  // CSD digit codes: one two-bit field per digit, code 2'b11 is never legal.
  localparam logic [1:0] CSD_0  = 2'b00;
  localparam logic [1:0] CSD_P1 = 2'b01;
  localparam logic [1:0] CSD_M1 = 2'b10;

  // FSM state encoding for the sequential converter.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_CONV = 2'b01;
  localparam logic [1:0] ST_HOLD = 2'b10;

  // True for any digit that contributes to the nonzero-digit count.
  function automatic logic csd_is_nz(input logic [1:0] dig);
    return (dig == CSD_P1) || (dig == CSD_M1);
  endfunction

endpackage

// File: rtl/bin2csd_digit.sv
// Purpose: combinational one-digit CSD recoder (x_i, x_(i+1), carry in -> digit, carry out).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the caller sequences digits.
//
// Ports:
//   x_i    - current binary bit
//   x_nxt  - next-higher binary bit, used to pick +1 vs -1 when t = 1
//   c_in   - incoming carry
//   dig    - CSD digit code (CSD_0 / CSD_P1 / CSD_M1)
//   c_out  - carry into the next digit position
module bin2csd_digit
  import bin2csd_pkg::*;
(
  input  logic       x_i,
  input  logic       x_nxt,
  input  logic       c_in,
  output logic [1:0] dig,
  output logic       c_out
);

  // t = x_i + c_in.
  //   t = 0 : digit 0, no carry
  //   t = 2 : digit 0, carry 1
  //   t = 1 : emit +1 if the next bit is 0, otherwise emit -1 and carry so
  //           the run of ones collapses into a single nonzero digit above it.
  always_comb begin
    dig   = CSD_0;
    c_out = 1'b0;
    if (x_i ^ c_in) begin
      if (x_nxt) begin
        dig   = CSD_M1;
        c_out = 1'b1;
      end else begin
        dig   = CSD_P1;
      end
    end else if (x_i & c_in) begin
      c_out = 1'b1;
    end
  end

endmodule

// File: rtl/bin2csd_seq.sv
// Purpose: serial binary-to-CSD converter, one digit per cycle, LSB first.
// Latency: out_valid rises W cycles after accept (signed) or W+1 (unsigned).
// Backpressure: result held in HOLD until out_ready; no input accepted until then.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid/in_ready   - input handshake; in_ready only while idle
//   in_x, in_signed     - word to convert and its interpretation
//   out_valid/out_ready - result handshake; out_valid only while holding
//   out_y               - CSD digits, digit i in bits [2i+1:2i]
//   out_nz              - number of nonzero digits in out_y
//   busy                - conversion in progress
module bin2csd_seq
  import bin2csd_pkg::*;
#(
  parameter int W   = 8,
  parameter int NZW = $clog2(W + 2)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_x,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*(W+1)-1:0] out_y,
  output logic [NZW-1:0]     out_nz,
  output logic               busy
);

  // Index must reach W+1 (the "next bit" of the last unsigned digit), and it
  // selects from a W+2 bit extended word, so size it to that word exactly.
  localparam int IW = $clog2(W + 2);

  logic [1:0]           state_q, state_d;
  logic [W-1:0]         x_q, x_d;
  logic                 sgn_q, sgn_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 carry_q, carry_d;
  logic [2*(W+1)-1:0]   y_q, y_d;
  logic [NZW-1:0]       nz_q, nz_d;

  logic                 ext_bit;
  logic [W+1:0]         x_ext;
  logic [IW-1:0]        idx_nxt;
  logic                 x_i, x_nxt;
  logic [1:0]           dig;
  logic                 c_out;
  logic                 last_dig;

  // Bits above the word are the sign bit in signed mode, zero otherwise.
  // Two extension bits cover x_(i+1) for the top unsigned digit at i = W.
  assign ext_bit = sgn_q & x_q[W-1];
  assign x_ext   = {ext_bit, ext_bit, x_q};
  assign idx_nxt = idx_q + IW'(1);
  assign x_i     = x_ext[idx_q];
  assign x_nxt   = x_ext[idx_nxt];

  // Signed mode stops after digit W-1: digit W stays at its cleared 00 and
  // the final carry (which equals the sign bit) is dropped, giving the
  // two's-complement value directly.
  assign last_dig = sgn_q ? (idx_q == IW'(W - 1)) : (idx_q == IW'(W));

  bin2csd_digit u_digit (
    .x_i   (x_i),
    .x_nxt (x_nxt),
    .c_in  (carry_q),
    .dig   (dig),
    .c_out (c_out)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    sgn_d   = sgn_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    y_d     = y_q;
    nz_d    = nz_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          x_d     = in_x;
          sgn_d   = in_signed;
          idx_d   = '0;
          carry_d = 1'b0;
          y_d     = '0;
          nz_d    = '0;
          state_d = ST_CONV;
        end
      end

      ST_CONV: begin
        for (int k = 0; k <= W; k++) begin
          if (idx_q == IW'(k)) begin
            y_d[2*k +: 2] = dig;
          end
        end
        if (csd_is_nz(dig)) begin
          nz_d = nz_q + NZW'(1);
        end
        carry_d = c_out;
        idx_d   = idx_nxt;
        if (last_dig) begin
          state_d = ST_HOLD;
        end
      end

      ST_HOLD: begin
        // out_y/out_nz are left untouched here and in IDLE; only an accept
        // or a reset changes them.
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      sgn_q   <= 1'b0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      y_q     <= '0;
      nz_q    <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      sgn_q   <= sgn_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      y_q     <= y_d;
      nz_q    <= nz_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_HOLD);
  assign busy      = (state_q == ST_CONV);
  assign out_y     = y_q;
  assign out_nz    = nz_q;

endmodule

// File: tb/tb_bin2csd_seq.sv
// Purpose: directed and exhaustive checks of bin2csd_seq at W=5.
// Latency: checks out_valid timing of W / W+1 cycles after accept.
// Backpressure: exercises held results with out_ready low and in_valid high.
module tb_bin2csd_seq;

  localparam int W   = 5;
  localparam int NZW = $clog2(W + 2);

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [W-1:0]       in_x;
  logic               in_signed;
  logic               out_valid;
  logic               out_ready;
  logic [2*(W+1)-1:0] out_y;
  logic [NZW-1:0]     out_nz;
  logic               busy;

  int checks;
  int failures;

  bin2csd_seq #(.W(W), .NZW(NZW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_nz    (out_nz),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [W-1:0] x, input logic s);
    in_x      = x;
    in_signed = s;
    in_valid  = 1'b1;
    step;
    in_valid  = 1'b0;
  endtask

  // Edges from accept until out_valid, capped at 20.
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      step;
      n++;
    end
  endtask

  task automatic release_hold;
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step;
    step;
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (out_y !== 12'h000) begin failures++; $display("FAIL reset_out_y got=%b exp=0", out_y); end
    checks++; if (out_nz !== 3'd0) begin failures++; $display("FAIL reset_out_nz got=%0d exp=0", out_nz); end
  endtask

  task automatic test_unsigned_7;
    int n;
    start(5'b00111, 1'b0);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL u7_busy got=%b exp=1", busy); end
    wait_valid(n);
    checks++; if (n != 6) begin failures++; $display("FAIL u7_latency got=%0d exp=6", n); end
    checks++; if (out_y !== 12'b00_00_01_00_00_10) begin failures++; $display("FAIL u7_out_y got=%b exp=000001000010", out_y); end
    checks++; if (out_nz !== 3'd2) begin failures++; $display("FAIL u7_out_nz got=%0d exp=2", out_nz); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL u7_hold_in_ready got=%b exp=0", in_ready); end
    release_hold;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL u7_idle got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid); end
    checks++; if (out_y !== 12'b00_00_01_00_00_10) begin failures++; $display("FAIL u7_idle_keep_y got=%b exp=000001000010", out_y); end
  endtask

  task automatic test_signed_neg1;
    int n;
    start(5'b11111, 1'b1);
    wait_valid(n);
    checks++; if (n != 5) begin failures++; $display("FAIL sneg1_latency got=%0d exp=5", n); end
    checks++; if (out_y !== 12'b00_00_00_00_00_10) begin failures++; $display("FAIL sneg1_out_y got=%b exp=000000000010", out_y); end
    checks++; if (out_nz !== 3'd1) begin failures++; $display("FAIL sneg1_out_nz got=%0d exp=1", out_nz); end
    release_hold;
  endtask

  task automatic test_unsigned_31;
    int n;
    start(5'b11111, 1'b0);
    wait_valid(n);
    checks++; if (n != 6) begin failures++; $display("FAIL u31_latency got=%0d exp=6", n); end
    checks++; if (out_y !== 12'b01_00_00_00_00_10) begin failures++; $display("FAIL u31_out_y got=%b exp=010000000010", out_y); end
    checks++; if (out_nz !== 3'd2) begin failures++; $display("FAIL u31_out_nz got=%0d exp=2", out_nz); end
    release_hold;
  endtask

  task automatic test_backpressure;
    int n;
    // 11 = 16 - 4 - 1
    start(5'b01011, 1'b0);
    wait_valid(n);
    checks++; if (out_y !== 12'b00_01_00_10_00_10) begin failures++; $display("FAIL bp_out_y got=%b exp=000100100010", out_y); end
    checks++; if (out_nz !== 3'd3) begin failures++; $display("FAIL bp_out_nz got=%0d exp=3", out_nz); end
    in_x      = 5'b00001;
    in_signed = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step;
      checks++; if (out_y !== 12'b00_01_00_10_00_10) begin failures++; $display("FAIL bp_stable_y cyc=%0d got=%b exp=000100100010", c, out_y); end
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL bp_hold cyc=%0d got in_ready=%b out_valid=%b busy=%b exp 0/1/0", c, in_ready, out_valid, busy); end
    end
    out_ready = 1'b1;
    step;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL bp_release got in_ready=%b out_valid=%b busy=%b exp 1/0/0", in_ready, out_valid, busy); end
    checks++; if (out_nz !== 3'd3) begin failures++; $display("FAIL bp_release_nz got=%0d exp=3", out_nz); end
  endtask

  task automatic test_reset_mid_conv;
    start(5'b00111, 1'b0);
    step;
    step;
    // Digits 0 and 1 written: -1 then 0.
    checks++; if (busy !== 1'b1 || out_y !== 12'b00_00_00_00_00_10) begin failures++; $display("FAIL midrst_pre got busy=%b y=%b exp busy=1 y=000000000010", busy, out_y); end
    rst = 1'b1;
    step;
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL midrst_state got in_ready=%b out_valid=%b busy=%b exp 1/0/0", in_ready, out_valid, busy); end
    checks++; if (out_y !== 12'h000) begin failures++; $display("FAIL midrst_out_y got=%b exp=0", out_y); end
    checks++; if (out_nz !== 3'd0) begin failures++; $display("FAIL midrst_out_nz got=%0d exp=0", out_nz); end
  endtask

  task automatic test_reset_priority;
    int n;
    start(5'b11111, 1'b0);
    wait_valid(n);
    out_ready = 1'b1;
    rst       = 1'b1;
    step;
    rst       = 1'b0;
    out_ready = 1'b0;
    checks++; if (out_y !== 12'h000 || out_nz !== 3'd0 || in_ready !== 1'b1) begin failures++; $display("FAIL prio_hold got y=%b nz=%0d in_ready=%b exp 0/0/1", out_y, out_nz, in_ready); end
    in_x      = 5'b10101;
    in_valid  = 1'b1;
    rst       = 1'b1;
    step;
    rst       = 1'b0;
    in_valid  = 1'b0;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL prio_accept got busy=%b in_ready=%b exp 0/1", busy, in_ready); end
  endtask

  task automatic test_sweep;
    int n, sum, cnt, exp_val, k;
    logic bad11, adj;
    logic [1:0] d, dp;
    logic [2*(W+1)-1:0] held;
    for (int s = 0; s < 2; s++) begin
      for (int v = 0; v < 32; v++) begin
        start(5'(v), 1'(s));
        wait_valid(n);
        checks++; if (n != (s != 0 ? 5 : 6)) begin failures++; $display("FAIL sweep_latency s=%0d x=%0d got=%0d exp=%0d", s, v, n, (s != 0 ? 5 : 6)); end
        exp_val = (s != 0 && v >= 16) ? v - 32 : v;
        sum = 0; cnt = 0; bad11 = 1'b0; adj = 1'b0; dp = 2'b00;
        for (int i = 0; i <= W; i++) begin
          d = out_y[2*i +: 2];
          if (d == 2'b01) begin sum += (1 << i); cnt++; end
          if (d == 2'b10) begin sum -= (1 << i); cnt++; end
          if (d == 2'b11) bad11 = 1'b1;
          if (d != 2'b00 && dp != 2'b00) adj = 1'b1;
          dp = d;
        end
        checks++; if (sum != exp_val) begin failures++; $display("FAIL sweep_value s=%0d x=%0d got=%0d exp=%0d y=%b", s, v, sum, exp_val, out_y); end
        checks++; if (adj !== 1'b0) begin failures++; $display("FAIL sweep_adjacent s=%0d x=%0d got y=%b exp no adjacent nonzero", s, v, out_y); end
        checks++; if (bad11 !== 1'b0) begin failures++; $display("FAIL sweep_code11 s=%0d x=%0d got y=%b exp no 11", s, v, out_y); end
        checks++; if (int'(out_nz) != cnt) begin failures++; $display("FAIL sweep_nz s=%0d x=%0d got=%0d exp=%0d", s, v, out_nz, cnt); end
        if (s != 0) begin
          checks++; if (out_y[2*W +: 2] !== 2'b00) begin failures++; $display("FAIL sweep_top_digit x=%0d got=%b exp=00", v, out_y[2*W +: 2]); end
        end
        // Random out_ready until the result drains; it must not move meanwhile.
        held = out_y;
        k = 0;
        out_ready = 1'($urandom_range(0, 1));
        while (out_valid && k < 8) begin
          step;
          k++;
          if (out_valid) begin
            checks++; if (out_y !== held) begin failures++; $display("FAIL sweep_hold s=%0d x=%0d got=%b exp=%b", s, v, out_y, held); end
          end
          out_ready = (k >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
        end
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL sweep_drain s=%0d x=%0d got in_ready=%b exp=1", s, v, in_ready); end
      end
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_x      = '0;
    in_signed = 1'b0;
    out_ready = 1'b0;
    test_reset;
    test_unsigned_7;
    test_signed_neg1;
    test_unsigned_31;
    test_backpressure;
    test_reset_mid_conv;
    test_reset_priority;
    test_sweep;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
